iddmm_result_sel: RTL and testbench

//  Read side of the iddmm_cal result FIFOs. After each cal_done it pops N words from the
//  "a" FIFO (raw Montgomery result) and the "sub" FIFO (result minus p) in lockstep. It

---
 rtl/iddmm_result_sel.sv | 145 ++++++++++++++
 tb/tb_iddmm_result_sel.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddmm_result_sel.sv
// iddmm_result_sel: read side of the iddmm_cal result FIFOs.
// After each cal_done it pops N word pairs from the "a" and "sub" FIFOs in
// lockstep. For each pair it keeps the word chosen by the latched sign and
// streams the kept words out least-significant first over valid/ready.
module iddmm_result_sel #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_done,
  input  logic              cal_sign,
  input  logic              fifo_empty_a,
  output logic              fifo_rd_en_a,
  input  logic [K-1:0]      fifo_rd_data_a,
  input  logic              fifo_empty_sub,
  output logic              fifo_rd_en_sub,
  input  logic [K-1:0]      fifo_rd_data_sub,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [K-1:0]      o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_err
);

  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  LAST_POP = CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q;
  logic              sign_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              err_q;

  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic              hd_q;
  logic [K-1:0]      buf_q [2];
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              pop;
  logic              xfer;
  logic              wr_ptr;

  assign o_valid        = (occ_q != 2'd0);
  assign xfer           = o_valid & o_ready;
  assign o_data         = o_valid ? buf_q[hd_q] : '0;
  assign o_idx          = idx_q;
  assign o_last         = o_valid & (idx_q == LAST_IDX);
  assign o_busy         = (state_q != S_IDLE);
  assign o_err          = err_q;
  assign fifo_rd_en_a   = pop;
  assign fifo_rd_en_sub = pop;
  // The in-flight word always lands in the slot just behind the current contents.
  assign wr_ptr         = hd_q ^ occ_q[0];

  // Pop decision and next buffer occupancy/index.
  // NOTE: every variable assigned in this block gets a default at the top, so no latch can form.
  always_comb begin
    pop   = 1'b0;
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
    idx_d = idx_q;
    // A word leaving this cycle frees its slot, so counting the occupancy net of
    // the transfer keeps a 1 word/cycle stream while never overfilling 2 slots.
    if ((state_q == S_RUN) && !fifo_empty_a && !fifo_empty_sub && (occ_d < 2'd2)) begin
      pop = 1'b1;
    end
    if (xfer) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
    end
  end

  // Result sequencing: latch sign, count pops, wait for the buffer to drain.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (cal_done && (state_q != S_IDLE)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (cal_done) begin
            sign_q   <= cal_sign;
            rd_cnt_q <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (pop) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == LAST_POP) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((occ_q == 2'd0) && !inflight_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Skid buffer control: in-flight flag, occupancy, head pointer, output index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      hd_q       <= 1'b0;
      idx_q      <= '0;
    end else begin
      inflight_q <= pop;
      occ_q      <= occ_d;
      idx_q      <= idx_d;
      if (xfer) begin
        hd_q <= ~hd_q;
      end
    end
  end

  // Skid buffer storage: capture the selected word the cycle after a pop.
  // NOTE: storage is deliberately not reset; o_data is forced to 0 whenever o_valid is low.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      buf_q[wr_ptr] <= sign_q ? fifo_rd_data_sub : fifo_rd_data_a;
    end
  end

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Self-checking bench for iddmm_result_sel: FIFO models, a scoreboard of the
// words each result must produce, and directed plus randomized scenarios.
`timescale 1ns/1ps
module tb_iddmm_result_sel;

  localparam int K = 256;
  localparam int N = 16;
  localparam int ADDR_W = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cal_done = 1'b0;
  logic              cal_sign = 1'b0;
  logic              fifo_empty_a = 1'b1;
  logic              fifo_rd_en_a;
  logic [K-1:0]      fifo_rd_data_a = '0;
  logic              fifo_empty_sub = 1'b1;
  logic              fifo_rd_en_sub;
  logic [K-1:0]      fifo_rd_data_sub = '0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [K-1:0]      o_data;
  logic [ADDR_W-1:0] o_idx;
  logic              o_last;
  logic              o_busy;
  logic              o_err;

  iddmm_result_sel #(.K(K), .N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cal_done         (cal_done),
    .cal_sign         (cal_sign),
    .fifo_empty_a     (fifo_empty_a),
    .fifo_rd_en_a     (fifo_rd_en_a),
    .fifo_rd_data_a   (fifo_rd_data_a),
    .fifo_empty_sub   (fifo_empty_sub),
    .fifo_rd_en_sub   (fifo_rd_en_sub),
    .fifo_rd_data_sub (fifo_rd_data_sub),
    .o_valid          (o_valid),
    .o_ready          (o_ready),
    .o_data           (o_data),
    .o_idx            (o_idx),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // External FIFO contents.
  logic [K-1:0] qa[$];
  logic [K-1:0] qs[$];

  // Reference model of the result in progress.
  logic [K-1:0] exp_q[$];
  logic         m_busy = 1'b0;
  logic         m_sign = 1'b0;
  logic         m_err = 1'b0;
  int           m_idx = 0;
  int           pops_left = 0;
  int           words_left = 0;
  int           pop_total = 0;

  // Log of transferred words.
  logic [K-1:0] log_data[$];
  int           log_idx[$];
  logic         log_last[$];

  int ready_mode = 0;  // 0: always ready, 1: random, 2: toggle/hold pattern
  int rcyc = 0;

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [K-1:0] rand_word();
    logic [K-1:0] w;
    for (int i = 0; i < K / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [K-1:0] a, input logic [K-1:0] s);
    qa.push_back(a);
    qs.push_back(s);
  endtask

  task automatic pulse_cal(input logic s);
    cal_done = 1'b1;
    cal_sign = s;
    @(posedge clk);
    if (m_busy) begin
      m_err = 1'b1;
    end else begin
      m_busy     = 1'b1;
      m_sign     = s;
      pops_left  = N;
      words_left = N;
    end
    #1;
    cal_done = 1'b0;
    cal_sign = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_log_timeout", log_data.size() >= n, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((o_busy || m_busy) && k < budget) begin
      tick(1);
      k++;
    end
    check("idle_timeout", !o_busy && !m_busy, 1'b1);
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_data"}, o_data, '0);
    check({tag, "_idx"}, o_idx, '0);
    check({tag, "_last"}, o_last, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_err"}, o_err, 1'b0);
    check({tag, "_rd_en"}, fifo_rd_en_a | fifo_rd_en_sub, 1'b0);
  endtask

  // FIFO models: pop on rd_en, data visible after the edge; empty flags track contents.
  always @(posedge clk) begin
    logic [K-1:0] wa, ws;
    if (rst_n) begin
      check("pop_lockstep", fifo_rd_en_a, fifo_rd_en_sub);
      if (fifo_rd_en_a) begin
        check("pop_within_n", pops_left != 0, 1'b1);
        check("pop_not_empty", (qa.size() != 0) && (qs.size() != 0), 1'b1);
        if (qa.size() != 0 && qs.size() != 0) begin
          wa = qa.pop_front();
          ws = qs.pop_front();
          fifo_rd_data_a   <= wa;
          fifo_rd_data_sub <= ws;
          exp_q.push_back(m_sign ? ws : wa);
        end
        if (pops_left != 0) pops_left--;
        pop_total++;
      end
    end
    fifo_empty_a   <= (qa.size() == 0);
    fifo_empty_sub <= (qs.size() == 0);
  end

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ($urandom_range(0, 2) != 0);
      default: o_ready = (rcyc >= 6 && rcyc < 11) ? 1'b0 : (rcyc >= 40) ? 1'b1 : ~rcyc[0];
    endcase
    rcyc = (ready_mode == 2) ? rcyc + 1 : 0;
  end

  // Output compare against the scoreboard on every cycle.
  logic         stall_q = 1'b0;
  logic [K-1:0] stall_data = '0;
  logic [ADDR_W-1:0] stall_idx = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", o_valid, 1'b1);
        check("stall_data", o_data, stall_data);
        check("stall_idx", o_idx, stall_idx);
      end
      if (o_valid) begin
        check("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("o_data", o_data, exp_q[0]);
          check("o_idx", o_idx, m_idx);
          check("o_last", o_last, m_idx == N - 1);
          if (o_ready) begin
            log_data.push_back(o_data);
            log_idx.push_back(int'(o_idx));
            log_last.push_back(o_last);
            void'(exp_q.pop_front());
            m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
            if (words_left > 0) words_left--;
            if (words_left == 0) m_busy = 1'b0;
          end
        end
      end
      stall_q    = o_valid & ~o_ready;
      stall_data = o_data;
      stall_idx  = o_idx;
      check("o_err", o_err, m_err);
      if (m_busy) check("o_busy", o_busy, 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pops0;
    logic s;

    // Reset state.
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // 1. Known preload, sign = 1 selects the sub words.
    for (int i = 0; i < N; i++) push_pair(K'(i), K'(32'h100 + i));
    tick(2);
    base  = log_data.size();
    pops0 = pop_total;
    pulse_cal(1'b1);
    wait_log(base + N, 200);
    wait_idle(50);
    for (int i = 0; i < N; i++) begin
      check("t1_data", log_data[base+i], K'(32'h100 + i));
      check("t1_idx", log_idx[base+i], i);
      check("t1_last", log_last[base+i], i == N - 1);
    end
    check("t1_pops", pop_total - pops0, N);

    // 2. Same preload, sign = 0, ready held: latency 2 and back-to-back words.
    for (int i = 0; i < N; i++) push_pair(K'(i), K'(32'h100 + i));
    tick(2);
    pulse_cal(1'b0);
    check("t2_pop_cycle1", fifo_rd_en_a, 1'b1);
    check("t2_valid_cycle1", o_valid, 1'b0);
    tick(1);
    check("t2_valid_edge1", o_valid, 1'b0);
    tick(1);
    check("t2_valid_edge2", o_valid, 1'b1);
    check("t2_word0", o_data, '0);
    for (int i = 1; i < N; i++) begin
      tick(1);
      check("t2_stream_valid", o_valid, 1'b1);
      check("t2_stream_data", o_data, K'(i));
    end
    check("t2_last", o_last, 1'b1);
    wait_idle(50);

    // 3. Random data; ready toggles 1010.. and holds 0 for 5 cycles.
    base = log_data.size();
    s = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) push_pair(rand_word(), rand_word());
    ready_mode = 2;
    tick(2);
    pulse_cal(s);
    wait_log(base + N, 200);
    wait_idle(50);
    ready_mode = 0;

    // 4. "a" full, "sub" fed one word every 3 cycles.
    base = log_data.size();
    for (int i = 0; i < N; i++) qa.push_back(K'(32'h200 + i));
    tick(2);
    pulse_cal(1'b1);
    for (int i = 0; i < N; i++) begin
      qs.push_back(K'(32'h300 + i));
      tick(3);
    end
    wait_log(base + N, 200);
    wait_idle(50);
    for (int i = 0; i < N; i++) check("t4_data", log_data[base+i], K'(32'h300 + i));

    // 5. Second cal_done mid-result: flagged and ignored.
    base = log_data.size();
    ready_mode = 1;
    s = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) push_pair(rand_word(), rand_word());
    tick(2);
    pulse_cal(s);
    tick(5);
    pulse_cal(~s);
    wait_log(base + N, 400);
    wait_idle(50);
    check("t5_err_sticky", o_err, 1'b1);
    check("t5_idle", o_busy, 1'b0);
    check("t5_count", log_data.size() - base, N);

    // 6. Reset after 7 words, then a fresh result.
    ready_mode = 0;
    base = log_data.size();
    for (int i = 0; i < N; i++) push_pair(rand_word(), rand_word());
    tick(2);
    pulse_cal(1'b0);
    wait_log(base + 7, 100);
    rst_n = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_err = 1'b0;
    m_idx = 0;
    pops_left = 0;
    words_left = 0;
    #1;
    check_all_zero("t6_reset");
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) push_pair(rand_word(), rand_word());
    tick(2);
    base = log_data.size();
    pulse_cal(1'b1);
    wait_log(base + N, 200);
    wait_idle(50);
    check("t6_restart_idx", log_idx[base], 0);

    // 7. Randomized results with irregular FIFO fill and random ready.
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      base = log_data.size();
      pulse_cal(1'($urandom_range(0, 1)));
      for (int i = 0; i < N; i++) begin
        push_pair(rand_word(), rand_word());
        tick($urandom_range(1, 3));
      end
      wait_log(base + N, 400);
      wait_idle(50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
